// File: rtl/ir_cmd_pkg.sv
// Shared NEC frame field positions, FSM state type and default key map for the IR command decoder.
package ir_cmd_pkg;

  localparam int ADDR_LSB = 0;
  localparam int KEY_LSB  = 16;
  localparam int NKEY_LSB = 24;
  localparam int FIELD_W  = 8;

  // Byte i selects command bit i: 1A,02,04,05,06,08,1E from bit 0 upwards.
  localparam logic [55:0] DEFAULT_KEY_MAP = 56'h1E08060504021A;

  typedef enum logic {IDLE, ACTIVE} ir_state_t;

endpackage

// File: rtl/ir_hold_timer.sv
// Dead-man hold timer: load sets the count to HOLD_CYCLES, en counts down and stops at zero.
module ir_hold_timer #(
  parameter int HOLD_CYCLES = 25_000_000,
  localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire,
  output logic zero
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(HOLD_CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);
  // A load in the final cycle suppresses the expiry.
  assign expire = en & ~load & (cnt == TW'(1));

endmodule

// File: rtl/ir_cmd_decoder.sv
// Decodes NEC IR frames into a held one-hot motor command with dead-man timeout and error count.
// Define IR_ADDR_CHECK_EN to also require hex_data[15:0] == ADDR for a frame to be valid.
module ir_cmd_decoder
  import ir_cmd_pkg::*;
#(
  parameter int                    N_CMDS      = 7,
  parameter logic [8*N_CMDS-1:0]   KEY_MAP     = DEFAULT_KEY_MAP,
  parameter int                    HOLD_CYCLES = 25_000_000,
  parameter logic [15:0]           ADDR        = 16'h6B86,
  localparam int IDX_W = (N_CMDS > 1) ? $clog2(N_CMDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_ready,
  input  logic [31:0]       hex_data,
  output logic [N_CMDS-1:0] cmd_onehot,
  output logic [IDX_W-1:0]  cmd_idx,
  output logic              cmd_active,
  output logic              cmd_new,
  output logic              timeout,
  output logic [7:0]        err_cnt
);

  ir_state_t state_q, state_d;
  logic data_ready_q;
  logic fe, valid, hit;
  logic [FIELD_W-1:0] key;
  logic [IDX_W-1:0] hit_idx;
  logic [N_CMDS-1:0] hit_onehot;
  logic timer_load, timer_en, timer_expire, timer_zero;
  logic [N_CMDS-1:0] onehot_d;
  logic [IDX_W-1:0] idx_d;
  logic new_d, timeout_d;
  logic [7:0] err_d;

  assign fe  = data_ready & ~data_ready_q;
  assign key = hex_data[KEY_LSB +: FIELD_W];

`ifdef IR_ADDR_CHECK_EN
  assign valid = (hex_data[NKEY_LSB +: FIELD_W] == ~key) &&
                 (hex_data[ADDR_LSB +: 2*FIELD_W] == ADDR);
`else
  logic unused_addr;
  assign unused_addr = ^{hex_data[ADDR_LSB +: 2*FIELD_W], ADDR};
  assign valid = (hex_data[NKEY_LSB +: FIELD_W] == ~key);
`endif

  // Downward scan so the lowest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_CMDS - 1; i >= 0; i--) begin
      if (KEY_MAP[8*i +: 8] == key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hit_onehot = '0;
    for (int i = 0; i < N_CMDS; i++) begin
      hit_onehot[i] = (hit_idx == IDX_W'(i));
    end
  end

  assign timer_load = fe & valid & hit;
  assign timer_en   = ~fe & ~timer_zero;

  ir_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire),
    .zero   (timer_zero)
  );

  always_comb begin
    state_d   = state_q;
    onehot_d  = cmd_onehot;
    idx_d     = cmd_idx;
    new_d     = 1'b0;
    timeout_d = 1'b0;
    err_d     = err_cnt;
    if (fe && !valid) begin
      if (err_cnt != 8'hFF) begin
        err_d = err_cnt + 8'd1;
      end
    end else if (fe) begin
      if (hit) begin
        state_d  = ACTIVE;
        onehot_d = hit_onehot;
        idx_d    = hit_idx;
        new_d    = (state_q == IDLE) || (hit_idx != cmd_idx);
      end else if (state_q == ACTIVE) begin
        state_d  = IDLE;
        onehot_d = '0;
        idx_d    = '0;
      end
    end else if ((state_q == ACTIVE) && timer_expire) begin
      state_d   = IDLE;
      onehot_d  = '0;
      idx_d     = '0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_ready_q <= 1'b0;
      cmd_onehot   <= '0;
      cmd_idx      <= '0;
      cmd_new      <= 1'b0;
      timeout      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      data_ready_q <= data_ready;
      cmd_onehot   <= onehot_d;
      cmd_idx      <= idx_d;
      cmd_new      <= new_d;
      timeout      <= timeout_d;
      err_cnt      <= err_d;
    end
  end

  assign cmd_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Directed self-checking bench for ir_cmd_decoder with a short 1000-cycle hold timeout.
module tb_ir_cmd_decoder;

  localparam int HOLD = 1000;
  localparam logic [15:0] ADDR = 16'h6B86;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ready;
  logic [31:0] hex_data;
  logic [6:0]  cmd_onehot;
  logic [2:0]  cmd_idx;
  logic        cmd_active;
  logic        cmd_new;
  logic        timeout;
  logic [7:0]  err_cnt;

  int checkCount = 0;
  int errorCount = 0;
  int pulseCount = 0;
  int expErr     = 0;

  ir_cmd_decoder #(.HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_ready (data_ready),
    .hex_data   (hex_data),
    .cmd_onehot (cmd_onehot),
    .cmd_idx    (cmd_idx),
    .cmd_active (cmd_active),
    .cmd_new    (cmd_new),
    .timeout    (timeout),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [15:0] addr, input logic [7:0] key);
    return {~key, key, addr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (timeout) pulseCount++;
    end
  endtask

  // One low cycle then one frame-ready cycle; returns 1 time unit after the frame edge.
  task automatic applyStimulus(input logic [31:0] frame);
    data_ready = 1'b0;
    tick(1);
    hex_data   = frame;
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_onehot"}, 32'(cmd_onehot), 32'h0);
    checkOutput({tag, "_idx"},    32'(cmd_idx),    32'h0);
    checkOutput({tag, "_active"}, 32'(cmd_active), 32'h0);
    checkOutput({tag, "_new"},    32'(cmd_new),    32'h0);
    checkOutput({tag, "_timeout"},32'(timeout),    32'h0);
    checkOutput({tag, "_err"},    32'(err_cnt),    32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    data_ready = 1'b0;
    hex_data   = '0;
    tick(2);
    checkAllZero("reset");
    rst = 1'b0;

    // Basic key press
    applyStimulus(mk(ADDR, 8'h02));
    checkOutput("t1_onehot", 32'(cmd_onehot), 32'h02);
    checkOutput("t1_idx",    32'(cmd_idx),    32'd1);
    checkOutput("t1_new",    32'(cmd_new),    32'd1);
    checkOutput("t1_active", 32'(cmd_active), 32'd1);
    tick(1);
    checkOutput("t1_new_clr", 32'(cmd_new), 32'd0);

    // Repeated frames keep the command alive; then it expires HOLD cycles after the last frame
    pulseCount = 0;
    for (int r = 0; r < 5; r++) begin
      tick(897);
      applyStimulus(mk(ADDR, 8'h02));
    end
    checkOutput("t2_no_timeout", 32'(pulseCount), 32'd0);
    checkOutput("t2_active",     32'(cmd_active), 32'd1);
    tick(HOLD - 1);
    checkOutput("t2_pre_expiry", 32'(pulseCount), 32'd0);
    checkOutput("t2_still_on",   32'(cmd_onehot), 32'h02);
    tick(1);
    checkOutput("t2_timeout",    32'(timeout),    32'd1);
    checkOutput("t2_off",        32'(cmd_onehot), 32'h0);
    checkOutput("t2_idle",       32'(cmd_active), 32'd0);
    tick(1);
    checkOutput("t2_pulse_1cyc", 32'(timeout),    32'd0);

    // Unmapped key while idle changes nothing
    applyStimulus(mk(ADDR, 8'h10));
    checkOutput("idle_miss_onehot", 32'(cmd_onehot), 32'h0);
    checkOutput("idle_miss_new",    32'(cmd_new),    32'd0);
    checkOutput("idle_miss_err",    32'(err_cnt),    32'd0);

    // Switch command, repeat, then explicit stop
    applyStimulus(mk(ADDR, 8'h02));
    applyStimulus(mk(ADDR, 8'h1E));
    checkOutput("t3_onehot", 32'(cmd_onehot), 32'h40);
    checkOutput("t3_idx",    32'(cmd_idx),    32'd6);
    checkOutput("t3_new",    32'(cmd_new),    32'd1);
    applyStimulus(mk(ADDR, 8'h1E));
    checkOutput("t3_same_new", 32'(cmd_new),    32'd0);
    checkOutput("t3_same_cmd", 32'(cmd_onehot), 32'h40);
    applyStimulus(mk(ADDR, 8'h10));
    checkOutput("t3_stop_onehot",  32'(cmd_onehot), 32'h0);
    checkOutput("t3_stop_idx",     32'(cmd_idx),    32'd0);
    checkOutput("t3_stop_active",  32'(cmd_active), 32'd0);
    checkOutput("t3_stop_timeout", 32'(timeout),    32'd0);

    // Integrity failures and saturation
    applyStimulus(mk(ADDR, 8'h02));
    applyStimulus({8'h00, 8'h02, ADDR});
    checkOutput("t4_err1",    32'(err_cnt),    32'd1);
    checkOutput("t4_keep",    32'(cmd_onehot), 32'h02);
    checkOutput("t4_active",  32'(cmd_active), 32'd1);
    checkOutput("t4_new",     32'(cmd_new),    32'd0);
    for (int r = 0; r < 299; r++) begin
      applyStimulus({8'h00, 8'h02, ADDR});
    end
    checkOutput("t4_err_sat", 32'(err_cnt), 32'd255);

    // Frame landing on the expiry cycle reloads the timer
    applyStimulus(mk(ADDR, 8'h02));
    tick(HOLD - 2);
    pulseCount = 0;
    applyStimulus(mk(ADDR, 8'h02));
    checkOutput("t5_race_timeout", 32'(timeout),    32'd0);
    checkOutput("t5_race_cmd",     32'(cmd_onehot), 32'h02);
    checkOutput("t5_race_active",  32'(cmd_active), 32'd1);
    tick(HOLD - 1);
    checkOutput("t5_reload_pulses", 32'(pulseCount), 32'd0);
    checkOutput("t5_reload_active", 32'(cmd_active), 32'd1);
    tick(1);
    checkOutput("t5_reload_expire", 32'(timeout),    32'd1);

    // Reset mid-hold
    applyStimulus(mk(ADDR, 8'h1E));
    tick(5);
    rst = 1'b1;
    tick(1);
    checkAllZero("t5_rst");
    rst = 1'b0;

    // Level held high counts as one frame
    hex_data   = {8'h00, 8'h04, ADDR};
    data_ready = 1'b1;
    tick(6);
    data_ready = 1'b0;
    tick(1);
    checkOutput("held_high_err", 32'(err_cnt), 32'd1);
    expErr = 1;

    // Foreign address
    applyStimulus(mk(16'h1234, 8'h04));
`ifdef IR_ADDR_CHECK_EN
    expErr++;
    checkOutput("t6_addr_err",    32'(err_cnt),    32'(expErr));
    checkOutput("t6_addr_onehot", 32'(cmd_onehot), 32'h0);
`else
    checkOutput("t6_addr_err",    32'(err_cnt),    32'(expErr));
    checkOutput("t6_addr_onehot", 32'(cmd_onehot), 32'h04);
    checkOutput("t6_addr_idx",    32'(cmd_idx),    32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
